// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture front-end.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam int DW_DEF    = 10;
  localparam int DIV_W_DEF = 8;
  localparam int DEPTH_DEF = 256;

  // Address width of a buffer holding 'depth' entries (depth is a power of two).
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Sample-clock divider and ADC data sampler.
// Generates adc_clk from clk, latches the divider setting at reset release and
// on each load, registers adc_data on the adc_clk falling toggle and raises a
// one-cycle smp strobe. With ADC_AVG_EN defined, consecutive raw samples are
// averaged in pairs and smp fires once per pair.
module adc_clk_div
  import adc_capture_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             load,
  input  logic [DW-1:0]    adc_data,
  output logic             adc_clk,
  output logic             smp,
  output logic [DW-1:0]    cur,
  output logic [DW-1:0]    prev
);

  logic             started_q, started_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             adc_clk_q, adc_clk_d;
  logic             smp_q, smp_d;
  logic [DW-1:0]    cur_q, cur_d;
  logic [DW-1:0]    prev_q, prev_d;
  logic             wrap;
  logic             fall;
`ifdef ADC_AVG_EN
  logic             phase_q, phase_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic [DW:0]      sum;
`endif

  // >= rather than == so a smaller divider loaded mid-count still wraps.
  assign wrap = (cnt_q >= div_q);
  assign fall = started_q && wrap && adc_clk_q;

  // Divider count, clock toggle and sample capture.
  always_comb begin
    started_d = started_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    adc_clk_d = adc_clk_q;
    smp_d     = 1'b0;
    cur_d     = cur_q;
    prev_d    = prev_q;
`ifdef ADC_AVG_EN
    phase_d   = phase_q;
    hold_d    = hold_q;
    sum       = '0;
`endif
    if (!started_q) begin
      // First cycle after reset release: pick up the divider setting.
      started_d = 1'b1;
      div_d     = div_cfg;
    end else begin
      if (wrap) begin
        cnt_d     = '0;
        adc_clk_d = ~adc_clk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (load) div_d = div_cfg;
    end
`ifdef ADC_AVG_EN
    if (load) begin
      // Restart pairing so the next raw sample opens a new pair.
      phase_d = 1'b0;
    end else if (fall) begin
      if (!phase_q) begin
        hold_d  = adc_data;
        phase_d = 1'b1;
      end else begin
        sum     = {1'b0, hold_q} + {1'b0, adc_data};
        cur_d   = sum[DW:1];
        prev_d  = cur_q;
        smp_d   = 1'b1;
        phase_d = 1'b0;
      end
    end
`else
    if (fall) begin
      cur_d  = adc_data;
      prev_d = cur_q;
      smp_d  = 1'b1;
    end
`endif
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
      smp_q     <= 1'b0;
`ifdef ADC_AVG_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      started_q <= started_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
      smp_q     <= smp_d;
`ifdef ADC_AVG_EN
      phase_q   <= phase_d;
`endif
    end
  end

  // Sample data registers; contents only matter once smp has fired.
  always_ff @(posedge clk) begin
    cur_q  <= cur_d;
    prev_q <= prev_d;
`ifdef ADC_AVG_EN
    hold_q <= hold_d;
`endif
  end

  assign adc_clk = adc_clk_q;
  assign smp     = smp_q;
  assign cur     = cur_q;
  assign prev    = prev_q;

endmodule

// File: rtl/adc_capture.sv
// ADC capture front-end: sample clock generation, level/edge trigger,
// DEPTH-sample capture buffer and host readback.
// Optional build macro ADC_AVG_EN: average raw samples in pairs before
// triggering and storage.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    adc_data,
  output logic             adc_clk,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic [DW-1:0]    trig_level,
  input  logic             trig_rising,
  input  logic             arm,
  input  logic             rd_en,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            prev_ok_q, prev_ok_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_seen_q, rd_seen_d;
  logic            smp;
  logic [DW-1:0]   cur;
  logic [DW-1:0]   prev;
  logic            arm_acc;
  logic            rd_fire;
  logic            trig_hit;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   ram_q;

  adc_clk_div #(
    .DW    (DW),
    .DIV_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_cfg  (div_cfg),
    .load     (arm_acc),
    .adc_data (adc_data),
    .adc_clk  (adc_clk),
    .smp      (smp),
    .cur      (cur),
    .prev     (prev)
  );

  assign arm_acc  = arm && ((state_q == IDLE) || (state_q == DONE));
  // DEPTH is a power of two, so rd_ptr < DEPTH is just a clear MSB.
  assign rd_fire  = rd_en && (state_q == DONE) && !arm && !rd_ptr_q[AW];
  assign trig_hit = prev_ok_q &&
                    (trig_rising ? ((prev < trig_level) && (cur >= trig_level))
                                 : ((prev >= trig_level) && (cur < trig_level)));

  // Next-state, buffer write and readback pointer logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    prev_ok_d  = prev_ok_q;
    we         = 1'b0;
    waddr      = '0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d   = WAIT_TRIG;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          prev_ok_d = 1'b0;
        end
      end
      WAIT_TRIG: begin
        if (smp) begin
          prev_ok_d = 1'b1;
          if (trig_hit) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = AW'(1);
            state_d  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (smp) begin
          we       = 1'b1;
          waddr    = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) state_d = DONE;
        end
      end
    endcase
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    rd_valid_d = rd_fire;
    rd_seen_d  = rd_seen_q | rd_fire;
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      prev_ok_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      prev_ok_q  <= prev_ok_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  // Capture buffer: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= cur;
    if (rd_fire) ram_q <= mem[rd_ptr_q[AW-1:0]];
  end

  // rd_data reads zero until the first read after reset, then holds.
  assign rd_data  = rd_seen_q ? ram_q : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
  assign done     = (state_q == DONE);

endmodule
